// File: rtl/fpa_pkg.sv
// fpa_pkg: shared state encoding and widths for the 1-4-3 floating-point adder controller
package fpa_pkg;
    localparam int MANT_W = 5;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ADD   = 3'd2,
        NLOAD = 3'd3,
        NORM  = 3'd4,
        DONE  = 3'd5,
        FIN   = 3'd6
    } state_t;
endpackage

// File: rtl/fpa_if.sv
// fpa_if: controller <-> datapath strobes, flags and start/busy/done handshake
interface fpa_if;
    import fpa_pkg::*;
    logic              start;
    logic              add_except;
    logic              norm_except;
    logic [MANT_W-1:0] mant;
    logic              load_en;
    logic              add_en;
    logic              norm_en;
    logic              norm_load;
    logic              shift_right;
    logic              shift_left;
    logic              done_en;
    logic              busy;
    logic              done;
    logic              err;
    modport master(
        input  start, add_except, norm_except, mant,
        output load_en, add_en, norm_en, norm_load, shift_right, shift_left, done_en, busy, done, err
    );
    modport slave(
        output start, add_except, norm_except, mant,
        input  load_en, add_en, norm_en, norm_load, shift_right, shift_left, done_en, busy, done, err
    );
endinterface

// File: rtl/fpa_controller.sv
// fpa_controller: sequences the FP adder datapath through load, add, normalize and result capture
module fpa_controller
    import fpa_pkg::*;
#(
    parameter int MAX_SHIFT = 4,
    parameter int CNT_W     = 3
) (
    input logic   clk,
    input logic   clr_n,
    fpa_if.master bus
);
    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic               busy_q, done_q, err_q;
    logic               stop, zero, shift;
    // Normalize decision is Mealy on the live mantissa; exceptions and the shift cap win
    assign stop            = bus.norm_except || cnt == CNT_W'(MAX_SHIFT);
    assign zero            = bus.mant == '0;
    assign bus.shift_right = state == NORM && !stop && !zero && bus.mant[4];
    assign bus.shift_left  = state == NORM && !stop && !zero && bus.mant[4:3] == 2'b00;
    assign shift           = bus.shift_right || bus.shift_left;
    assign bus.load_en     = state == LOAD;
    assign bus.add_en      = state == ADD;
    assign bus.norm_en     = state == NLOAD || state == NORM;
    assign bus.norm_load   = state == NLOAD;
    assign bus.done_en     = state == DONE;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    always_comb begin
        state_nx = state == IDLE  ? (bus.start ? LOAD : IDLE) :
                   state == LOAD  ? ADD :
                   state == ADD   ? NLOAD :
                   state == NLOAD ? (bus.add_except ? DONE : NORM) :
                   state == NORM  ? (shift ? NORM : DONE) :
                   state == DONE  ? FIN : IDLE;
    end
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            busy_q <= state_nx != IDLE;
            done_q <= state == FIN;
            cnt    <= state == NLOAD ? '0 : shift ? cnt + 1'b1 : cnt;
            err_q  <= (state == IDLE && bus.start) ? 1'b0 :
                      ((state == NLOAD && bus.add_except) || (state == NORM && stop)) ? 1'b1 : err_q;
        end
    end
endmodule

// File: tb/tb_fpa_controller.sv
// tb_fpa_controller: directed vectors against a small behavioural datapath model
module tb_fpa_controller;
    import fpa_pkg::*;
    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic [4:0] sc_mant = '0, mant_a = '0, mant_n = '0, res_mant = '0;
    logic [3:0] sc_exp = '0, exp_n = '0, res_exp = '0;
    logic       sc_except = 1'b0, sc_freeze = 1'b0;
    int         n_cmp = 0, n_bad = 0;
    always #5 clk = ~clk;
    fpa_if bus();
    fpa_controller #(.MAX_SHIFT(4), .CNT_W(3)) dut (.clk(clk), .clr_n(clr_n), .bus(bus));
    // Datapath stand-in; sc_freeze pins the normalize regs so the shift cap can be reached
    assign bus.mant        = bus.norm_en ? mant_n : mant_a;
    assign bus.norm_except = bus.norm_en && exp_n == 4'hf;
    assign bus.add_except  = sc_except;
    always @(posedge clk) begin
        if (bus.add_en) mant_a <= sc_mant;
        if (bus.norm_en && bus.norm_load) begin
            mant_n <= mant_a;
            exp_n  <= sc_exp;
        end else if (bus.shift_right && !sc_freeze) begin
            mant_n <= mant_n >> 1;
            exp_n  <= exp_n + 4'd1;
        end else if (bus.shift_left && !sc_freeze) begin
            mant_n <= mant_n << 1;
            exp_n  <= exp_n - 4'd1;
        end
        if (bus.done_en) begin
            res_mant <= mant_n;
            res_exp  <= exp_n;
        end
    end
    function automatic int outs();
        return {bus.load_en, bus.add_en, bus.norm_en, bus.norm_load, bus.shift_right,
                bus.shift_left, bus.done_en, bus.busy, bus.done, bus.err};
    endfunction
    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic run_op(input string tag, input logic [4:0] m, input logic [3:0] e, input bit ex,
                          input bit frz, input bit pulse, input int lat, input int nsr, input int nsl,
                          input int err_exp, input int rexp, input int rmant);
        int sr = 0, sl = 0, both = 0, nrm = 0, dn = 0, got_lat = -1, busy_bad = 0, err_done = -1;
        sc_mant = m; sc_exp = e; sc_except = ex; sc_freeze = frz;
        @(negedge clk) bus.start = 1'b1;
        @(posedge clk) #1 bus.start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            sr   += int'(bus.shift_right);
            sl   += int'(bus.shift_left);
            both += int'(bus.shift_right && bus.shift_left);
            nrm  += int'(bus.norm_en && !bus.norm_load);
            if (bus.done) begin
                dn++;
                if (got_lat < 0) begin
                    got_lat  = i - 1;
                    err_done = int'(bus.err);
                end
            end
            if (got_lat < 0 && !bus.busy) busy_bad++;
            if (pulse && (bus.add_en || (bus.norm_en && !bus.norm_load))) bus.start = 1'b1;
            @(posedge clk) #1 bus.start = 1'b0;
        end
        check({tag, " latency"}, got_lat, lat);
        check({tag, " shift_right"}, sr, nsr);
        check({tag, " shift_left"}, sl, nsl);
        check({tag, " both_shifts"}, both, 0);
        check({tag, " norm_cycles"}, nrm, ex ? 0 : nsr + nsl + 1);
        check({tag, " done_pulses"}, dn, 1);
        check({tag, " busy_gap"}, busy_bad, 0);
        check({tag, " err"}, err_done, err_exp);
        if (!ex) begin
            check({tag, " ans_exp"}, int'(res_exp), rexp);
            check({tag, " ans_mant"}, int'(res_mant[2:0]), rmant);
        end
    endtask
    initial begin
        int dn, w;
        bus.start = 1'b0;
        #12 check("reset_outs", outs(), 0);
        @(negedge clk) clr_n = 1'b1;
        run_op("c1_same_sign", 5'b10000, 4'd5,  1'b0, 1'b0, 1'b0, 7,  1, 0, 0, 6,  0);
        run_op("c2_opp_sign",  5'b00100, 4'd5,  1'b0, 1'b0, 1'b0, 7,  0, 1, 0, 4,  0);
        run_op("c3_add_exc",   5'b00000, 4'd6,  1'b1, 1'b0, 1'b0, 5,  0, 0, 1, 0,  0);
        run_op("c4_norm_exc",  5'b11110, 4'd14, 1'b0, 1'b0, 1'b0, 7,  1, 0, 1, 15, 7);
        run_op("zero_mant",    5'b00000, 4'd3,  1'b0, 1'b0, 1'b0, 6,  0, 0, 0, 3,  0);
        run_op("already_norm", 5'b01101, 4'd7,  1'b0, 1'b0, 1'b0, 6,  0, 0, 0, 7,  5);
        run_op("three_left",   5'b00001, 4'd5,  1'b0, 1'b0, 1'b0, 9,  0, 3, 0, 2,  0);
        run_op("max_shift",    5'b10000, 4'd5,  1'b0, 1'b1, 1'b0, 10, 4, 0, 1, 5,  0);
        run_op("exp15_first",  5'b10000, 4'd15, 1'b0, 1'b0, 1'b0, 6,  0, 0, 1, 15, 0);
        // Abort mid-normalize: everything drops at once and no done follows
        sc_mant = 5'b00100; sc_exp = 4'd5; sc_except = 1'b0; sc_freeze = 1'b0;
        @(negedge clk) bus.start = 1'b1;
        @(posedge clk) #1 bus.start = 1'b0;
        w = 0;
        while (!(bus.norm_en && !bus.norm_load) && w < 10) begin
            @(posedge clk) #1;
            w++;
        end
        check("c5_reached_norm", int'(bus.norm_en && !bus.norm_load), 1);
        #2 clr_n = 1'b0;
        #1 check("c5_async_outs", outs(), 0);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            dn += int'(bus.done);
        end
        check("c5_no_done", dn, 0);
        check("c5_idle_busy", int'(bus.busy), 0);
        run_op("c5_restart",   5'b10000, 4'd5,  1'b0, 1'b0, 1'b0, 7,  1, 0, 0, 6,  0);
        run_op("c6_start_ign", 5'b10000, 4'd5,  1'b0, 1'b0, 1'b1, 7,  1, 0, 0, 6,  0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
